// File: rtl/microseq_ctrl.sv
// Microcode sequencer for the 8-bit SAP-style CPU.
// Steps T-states for the current opcode and drives the 16-bit control word
// {HLT,MI,RI,RO,IO,II,AI,AO,SO,SU,BI,OI,CE,CO,J,FI}. Instruction length can
// follow the opcode, or every instruction can be padded to MAX_STEPS for
// legacy timing. Conditional jumps read the flags, HLT latches a sticky halt,
// and every completed instruction bumps a wrapping counter.
`timescale 1ns/1ps
module microseq_ctrl #(
    parameter int unsigned OP_W      = 4,
    parameter int unsigned STEP_W    = 3,
    parameter int unsigned MAX_STEPS = 5,
    parameter bit          FIXED_LEN = 1'b0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [OP_W-1:0]   opcode,
    input  logic [1:0]        flags,
    output logic [15:0]       ctrl_wrd,
    output logic [STEP_W-1:0] step,
    output logic              last_step,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt
);

    // Bad parameter sets are rejected at elaboration rather than silently misbehaving.
    if (MAX_STEPS < 5 || MAX_STEPS > (1 << STEP_W)) begin : g_bad_max_steps
        $error("microseq_ctrl: MAX_STEPS must lie in 5..2**STEP_W");
    end
    if (OP_W < 4) begin : g_bad_op_w
        $error("microseq_ctrl: OP_W must be at least 4");
    end

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } op_e;

    // Step indices and lengths; lengths carry one extra bit so 2**STEP_W fits.
    localparam logic [STEP_W-1:0] S0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] S1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4 = STEP_W'(4);

    localparam logic [STEP_W:0] L1   = (STEP_W+1)'(1);
    localparam logic [STEP_W:0] L2   = (STEP_W+1)'(2);
    localparam logic [STEP_W:0] L3   = (STEP_W+1)'(3);
    localparam logic [STEP_W:0] L4   = (STEP_W+1)'(4);
    localparam logic [STEP_W:0] L5   = (STEP_W+1)'(5);
    localparam logic [STEP_W:0] LMAX = (STEP_W+1)'(MAX_STEPS);

    localparam logic [15:0] CW_FETCH0 = 16'h4004;  // CO|MI
    localparam logic [15:0] CW_FETCH1 = 16'h1408;  // RO|II|CE
    localparam logic [15:0] CW_HALT   = 16'h8000;  // HLT
    localparam logic [15:0] CW_JUMP   = 16'h0802;  // IO|J

    logic [STEP_W-1:0] step_q, step_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    logic              op_hi_nz;
    op_e               op_dec;
    logic [STEP_W:0]   inst_len;
    logic [15:0]       exec_wrd;
    logic [15:0]       ctrl_wrd_c;
    logic              last_step_c;

    // Any set bit above the 4-bit opcode field forces NOP.
    assign op_hi_nz = |(opcode >> 4);

    // Map the raw opcode onto the known instructions; unknown codes run as NOP.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        op_dec = OP_NOP;
        if (!op_hi_nz) begin
            case (opcode[3:0])
                4'h1:    op_dec = OP_LDA;
                4'h2:    op_dec = OP_ADD;
                4'h3:    op_dec = OP_SUB;
                4'h4:    op_dec = OP_STA;
                4'h5:    op_dec = OP_LDI;
                4'h6:    op_dec = OP_JMP;
                4'h7:    op_dec = OP_JC;
                4'h8:    op_dec = OP_JZ;
                4'hE:    op_dec = OP_OUT;
                4'hF:    op_dec = OP_HLT;
                default: op_dec = OP_NOP;
            endcase
        end
    end

    // Execute-phase microcode and instruction length; steps past the length stay 0x0000.
    always_comb begin
        inst_len = L2;
        exec_wrd = 16'h0000;
        case (op_dec)
            OP_LDA: begin
                inst_len = L4;
                if (step_q == S2)      exec_wrd = 16'h4800;
                else if (step_q == S3) exec_wrd = 16'h1200;
            end
            OP_ADD: begin
                inst_len = L5;
                if (step_q == S2)      exec_wrd = 16'h4800;
                else if (step_q == S3) exec_wrd = 16'h1020;
                else if (step_q == S4) exec_wrd = 16'h0281;
            end
            OP_SUB: begin
                inst_len = L5;
                if (step_q == S2)      exec_wrd = 16'h4800;
                else if (step_q == S3) exec_wrd = 16'h1020;
                else if (step_q == S4) exec_wrd = 16'h02C1;
            end
            OP_STA: begin
                inst_len = L4;
                if (step_q == S2)      exec_wrd = 16'h4800;
                else if (step_q == S3) exec_wrd = 16'h2100;
            end
            OP_LDI: begin
                inst_len = L3;
                if (step_q == S2) exec_wrd = 16'h0A00;
            end
            OP_JMP: begin
                inst_len = L3;
                if (step_q == S2) exec_wrd = CW_JUMP;
            end
            OP_JC: begin
                inst_len = L3;
                if (step_q == S2 && flags[0]) exec_wrd = CW_JUMP;
            end
            OP_JZ: begin
                inst_len = L3;
                if (step_q == S2 && flags[1]) exec_wrd = CW_JUMP;
            end
            OP_OUT: begin
                inst_len = L3;
                if (step_q == S2) exec_wrd = 16'h0110;
            end
            OP_HLT: begin
                inst_len = L3;
                if (step_q == S2) exec_wrd = CW_HALT;
            end
            default: ;
        endcase
        if (FIXED_LEN) inst_len = LMAX;
    end

    // Final control word: halt overrides everything, fetch words are opcode-independent.
    always_comb begin
        ctrl_wrd_c = exec_wrd;
        if (halted_q)            ctrl_wrd_c = CW_HALT;
        else if (step_q == S0)   ctrl_wrd_c = CW_FETCH0;
        else if (step_q == S1)   ctrl_wrd_c = CW_FETCH1;
    end

    assign last_step_c = ({1'b0, step_q} == (inst_len - L1)) && !halted_q;

    // Next state: advance or wrap on enabled edges, latch halt at HLT step 2.
    always_comb begin
        step_d      = step_q;
        halted_d    = halted_q;
        instr_cnt_d = instr_cnt_q;
        if (enable && !halted_q) begin
            if (op_dec == OP_HLT && step_q == S2) begin
                halted_d = 1'b1;
            end else if (last_step_c) begin
                step_d      = S0;
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            end else begin
                step_d = step_q + S1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            step_q      <= S0;
            halted_q    <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            step_q      <= step_d;
            halted_q    <= halted_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign ctrl_wrd  = ctrl_wrd_c;
    assign step      = step_q;
    assign last_step = last_step_c;
    assign halted    = halted_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Testbench for microseq_ctrl: one variable-length and one fixed-length instance.
// Each driven cycle pushes its expected outputs (from a small reference model of
// the microcode table) to a scoreboard; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_microseq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_v, en_f;
    logic [3:0]  op_v, op_f;
    logic [1:0]  flags;

    logic [15:0] wrd_v, wrd_f;
    logic [2:0]  step_v, step_f;
    logic        last_v, last_f;
    logic        halt_v, halt_f;
    logic [7:0]  cnt_v, cnt_f;

    always #5 clk = ~clk;

    microseq_ctrl #(.FIXED_LEN(1'b0)) u_var (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en_v),
        .opcode    (op_v),
        .flags     (flags),
        .ctrl_wrd  (wrd_v),
        .step      (step_v),
        .last_step (last_v),
        .halted    (halt_v),
        .instr_cnt (cnt_v)
    );

    microseq_ctrl #(.FIXED_LEN(1'b1)) u_fix (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en_f),
        .opcode    (op_f),
        .flags     (flags),
        .ctrl_wrd  (wrd_f),
        .step      (step_f),
        .last_step (last_f),
        .halted    (halt_f),
        .instr_cnt (cnt_f)
    );

    typedef struct {
        string       tag;
        bit          sel;     // 0 = variable-length DUT, 1 = fixed-length DUT
        logic [15:0] wrd;
        logic [2:0]  step;
        logic        last;
        logic        halted;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state, one slot per DUT.
    int         m_step[2];
    bit         m_halt[2];
    logic [7:0] m_cnt[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_len(input logic [3:0] op, input bit fixed);
        if (fixed) return 5;
        case (op)
            4'h1, 4'h4:                      return 4;
            4'h2, 4'h3:                      return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
            default:                         return 2;
        endcase
    endfunction

    function automatic logic [15:0] ref_word(input logic [3:0] op, input int st, input logic [1:0] fl);
        if (st == 0) return 16'h4004;
        if (st == 1) return 16'h1408;
        if (st == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: return 16'h4800;
                4'h5: return 16'h0A00;
                4'h6: return 16'h0802;
                4'h7: return fl[0] ? 16'h0802 : 16'h0000;
                4'h8: return fl[1] ? 16'h0802 : 16'h0000;
                4'hE: return 16'h0110;
                4'hF: return 16'h8000;
                default: return 16'h0000;
            endcase
        end
        if (st == 3) begin
            case (op)
                4'h1: return 16'h1200;
                4'h2, 4'h3: return 16'h1020;
                4'h4: return 16'h2100;
                default: return 16'h0000;
            endcase
        end
        if (st == 4) begin
            if (op == 4'h2) return 16'h0281;
            if (op == 4'h3) return 16'h02C1;
        end
        return 16'h0000;
    endfunction

    // Reference model for the variable-length DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_step[0] <= 0;
            m_halt[0] <= 1'b0;
            m_cnt[0]  <= 8'd0;
        end else if (en_v && !m_halt[0]) begin
            if (op_v == 4'hF && m_step[0] == 2) m_halt[0] <= 1'b1;
            else if (m_step[0] == ref_len(op_v, 1'b0) - 1) begin
                m_step[0] <= 0;
                m_cnt[0]  <= m_cnt[0] + 8'd1;
            end else m_step[0] <= m_step[0] + 1;
        end
    end

    // Reference model for the fixed-length DUT.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_step[1] <= 0;
            m_halt[1] <= 1'b0;
            m_cnt[1]  <= 8'd0;
        end else if (en_f && !m_halt[1]) begin
            if (op_f == 4'hF && m_step[1] == 2) m_halt[1] <= 1'b1;
            else if (m_step[1] == ref_len(op_f, 1'b1) - 1) begin
                m_step[1] <= 0;
                m_cnt[1]  <= m_cnt[1] + 8'd1;
            end else m_step[1] <= m_step[1] + 1;
        end
    end

    task automatic cmp(input exp_t e, input logic [15:0] w, input logic [2:0] s,
                       input logic l, input logic h, input logic [7:0] c);
        check({e.tag, "/wrd"},  32'(w), 32'(e.wrd));
        check({e.tag, "/step"}, 32'(s), 32'(e.step));
        check({e.tag, "/last"}, 32'(l), 32'(e.last));
        check({e.tag, "/halt"}, 32'(h), 32'(e.halted));
        check({e.tag, "/cnt"},  32'(c), 32'(e.cnt));
    endtask

    // Scoreboard monitor: outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            if (sb_q[0].sel) cmp(sb_q[0], wrd_f, step_f, last_f, halt_f, cnt_f);
            else             cmp(sb_q[0], wrd_v, step_v, last_v, halt_v, cnt_v);
            void'(sb_q.pop_front());
        end
    end

    // Drive one cycle on the selected DUT (the other is held), push its expectation, take the edge.
    task automatic tick(input bit sel, input bit en, input logic [3:0] op, input string tag);
        exp_t e;
        if (sel) begin
            en_f = en; op_f = op; en_v = 1'b0;
        end else begin
            en_v = en; op_v = op; en_f = 1'b0;
        end
        e.tag    = tag;
        e.sel    = sel;
        e.step   = 3'(m_step[sel]);
        e.halted = m_halt[sel];
        e.cnt    = m_cnt[sel];
        if (m_halt[sel]) begin
            e.wrd  = 16'h8000;
            e.last = 1'b0;
        end else begin
            e.wrd  = ref_word(op, m_step[sel], flags);
            e.last = (m_step[sel] == ref_len(op, sel) - 1);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One full instruction; step 0 carries a junk opcode since only fetch words appear there.
    task automatic run_instr(input bit sel, input logic [3:0] op, input string tag);
        int n;
        n = ref_len(op, sel);
        for (int k = 0; k < n; k++) begin
            tick(sel, 1'b1, (k == 0) ? (op ^ 4'h9) : op, tag);
        end
    endtask

    task automatic pulse_reset(input bit sel, input logic [3:0] op, input string tag);
        rst_n = 1'b0;
        tick(sel, 1'b0, op, tag);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en_v = 1'b0; en_f = 1'b0;
        op_v = 4'h0; op_f = 4'h0;
        flags = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset lands mid-ADD at step 3 with enable low.
        tick(0, 1'b1, 4'h0, "add_rst");
        tick(0, 1'b1, 4'h2, "add_rst");
        tick(0, 1'b1, 4'h2, "add_rst");
        tick(0, 1'b0, 4'h2, "add_rst_s3");
        pulse_reset(0, 4'h2, "add_rst_edge");
        tick(0, 1'b0, 4'h2, "after_rst");
        check("after_rst_wrd", 32'(wrd_v), 32'h4004);

        // Variable-length instructions.
        run_instr(0, 4'h1, "lda");
        check("lda_cnt", 32'(cnt_v), 32'd1);
        run_instr(0, 4'h3, "sub");
        run_instr(0, 4'h4, "sta");
        run_instr(0, 4'h5, "ldi");
        run_instr(0, 4'h6, "jmp");
        run_instr(0, 4'hE, "out");
        run_instr(0, 4'h0, "nop");
        run_instr(0, 4'h9, "undef9");

        // ADD with enable dropped at step 3 for three cycles.
        tick(0, 1'b1, 4'h0, "add_hold");
        tick(0, 1'b1, 4'h2, "add_hold");
        tick(0, 1'b1, 4'h2, "add_hold");
        for (int k = 0; k < 3; k++) tick(0, 1'b0, 4'h2, "add_hold_s3");
        tick(0, 1'b1, 4'h2, "add_hold_s3");
        tick(0, 1'b1, 4'h2, "add_s4");

        // Conditional jumps, including flag toggles while parked at step 2.
        flags = 2'b01; run_instr(0, 4'h7, "jc_c1");
        flags = 2'b00; run_instr(0, 4'h7, "jc_c0");
        tick(0, 1'b1, 4'h0, "jc_tog");
        tick(0, 1'b1, 4'h7, "jc_tog");
        flags = 2'b01; tick(0, 1'b0, 4'h7, "jc_tog_f1");
        flags = 2'b00; tick(0, 1'b0, 4'h7, "jc_tog_f0");
        flags = 2'b01; tick(0, 1'b1, 4'h7, "jc_tog_f1b");
        flags = 2'b10; run_instr(0, 4'h8, "jz_z1");
        flags = 2'b01; run_instr(0, 4'h8, "jz_z0");
        flags = 2'b00;

        // Fixed-length instance: everything pads to five steps.
        pulse_reset(1, 4'h0, "fix_rst");
        run_instr(1, 4'h1, "fix_lda");
        run_instr(1, 4'h0, "fix_nop");
        run_instr(1, 4'h2, "fix_add");
        check("fix_cnt", 32'(cnt_f), 32'd3);
        run_instr(1, 4'hF, "fix_hlt");
        for (int k = 0; k < 4; k++) tick(1, 1'b1, 4'hF, "fix_halted");
        pulse_reset(1, 4'hF, "fix_hlt_rst");
        tick(1, 1'b1, 4'h1, "fix_after_rst");

        // Halt: sticky through enabled edges and opcode changes, cleared only by reset.
        run_instr(0, 4'hF, "hlt");
        for (int k = 0; k < 10; k++) tick(0, 1'b1, 4'hF, "halted");
        tick(0, 1'b1, 4'h1, "halted_op");
        tick(0, 1'b0, 4'h1, "halted_dis");
        check("halt_step", 32'(step_v), 32'd2);
        pulse_reset(0, 4'hF, "hlt_rst");
        tick(0, 1'b1, 4'h0, "hlt_after_rst");
        check("hlt_after_rst_halt", 32'(halt_v), 32'd0);

        // Counter wrap: 256 NOPs from a clean reset return instr_cnt to zero.
        pulse_reset(0, 4'h0, "wrap_rst");
        for (int k = 0; k < 256; k++) run_instr(0, 4'h0, "nop_wrap");
        check("cnt_wrap", 32'(cnt_v), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
